// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and the instruction memory.
interface fetch_stage_if;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IGnt;
  logic        IValid;
  logic [31:0] IRdata;

  modport master (output IReq, output IAddr, input IGnt, input IValid, input IRdata);
  modport slave  (input IReq, input IAddr, output IGnt, output IValid, output IRdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS32 fetch stage: PC, one-outstanding imem handshake, one-entry fetch buffer and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds saturating StallCnt/SquashCnt outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcE,
  input  logic [31:0]        PCBranchE,
  fetch_stage_if.master      imem,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD,
  output logic               IMemBusy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        StallCnt,
  output logic [31:0]        SquashCnt
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetchState_e;

  fetchState_e state_r;
  fetchState_e nextState_s;

  logic [31:0] pcF_r;
  logic [31:0] reqPc_r;
  logic [31:0] iBuf_r;
  logic [31:0] bufPc_r;
  logic        bufValid_r;

  logic        issue_s;
  logic        accept_s;
  logic        respKeep_s;
  logic        squash_s;

  assign imem.IAddr = pcF_r;
  assign imem.IReq  = issue_s;

  // State register
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_r <= FETCH;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state logic; a redirect while waiting turns the outstanding access into a discard
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      FETCH: begin
        if (accept_s) nextState_s = WAIT;
        else          nextState_s = FETCH;
      end
      WAIT: begin
        if (imem.IValid) nextState_s = FETCH;
        else if (PCSrcE) nextState_s = DRAIN;
        else             nextState_s = WAIT;
      end
      DRAIN: begin
        if (imem.IValid) nextState_s = FETCH;
        else             nextState_s = DRAIN;
      end
      default: nextState_s = FETCH;
    endcase
  end

  // Output and handshake decode; a request only issues when the buffer is empty or draining now
  always_comb begin
    issue_s    = (state_r == FETCH) & CLR & ~StallF & (~bufValid_r | ~StallD) & ~PCSrcE;
    accept_s   = issue_s & imem.IGnt;
    respKeep_s = (state_r == WAIT) & imem.IValid & ~PCSrcE;
    squash_s   = imem.IValid & ((state_r == DRAIN) | ((state_r == WAIT) & PCSrcE));
    IMemBusy   = (state_r != FETCH);
  end

  // PC, request address latch and fetch buffer; the PC only advances on a completed fetch
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      pcF_r      <= RESET_PC;
      reqPc_r    <= RESET_PC;
      iBuf_r     <= NOP_INSTR;
      bufPc_r    <= 32'h0000_0000;
      bufValid_r <= 1'b0;
    end else begin
      if (accept_s) reqPc_r <= pcF_r;
      if (PCSrcE)          pcF_r <= PCBranchE;
      else if (respKeep_s) pcF_r <= reqPc_r + 32'd4;
      if (respKeep_s) begin
        iBuf_r  <= imem.IRdata;
        bufPc_r <= reqPc_r;
      end
      if (PCSrcE)          bufValid_r <= 1'b0;
      else if (respKeep_s) bufValid_r <= 1'b1;
      else if (!StallD)    bufValid_r <= 1'b0;
    end
  end

  // IF/ID register: flush beats stall beats load beats bubble
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      InstrD   <= NOP_INSTR;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (PCSrcE) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (bufValid_r) begin
      InstrD   <= iBuf_r;
      PCPlus4D <= bufPc_r + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] satInc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) satInc = val;
    else                      satInc = val + 32'd1;
  endfunction

  // Saturating stall and squash event counters
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      StallCnt  <= 32'h0000_0000;
      SquashCnt <= 32'h0000_0000;
    end else begin
      if (StallD && ValidD) StallCnt <= satInc(StallCnt);
      if (squash_s)         SquashCnt <= satInc(SquashCnt);
    end
  end
`else
  logic unusedSquash_s;
  assign unusedSquash_s = squash_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a latency-configurable imem model.
module tb_fetch_stage;

  logic        CLK;
  logic        CLR;
  logic        StallF;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCBranchE;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        IMemBusy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] SquashCnt;
`endif

  fetch_stage_if mem ();

  fetch_stage dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcE    (PCSrcE),
    .PCBranchE (PCBranchE),
    .imem      (mem),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .IMemBusy  (IMemBusy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .StallCnt  (StallCnt),
    .SquashCnt (SquashCnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int          nChecks = 0;
  int          nPass   = 0;
  int          lat;
  int          cnt;
  logic        pend;
  logic [31:0] pendAddr;
  logic        reqObs;
  logic [31:0] addrObs;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic chkD(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                      input logic valid);
    checkVal({tag, "_instr"}, InstrD, instr);
    checkVal({tag, "_valid"}, {31'd0, ValidD}, {31'd0, valid});
    if (valid) checkVal({tag, "_pc4"}, PCPlus4D, pc4);
  endtask

  // One clock cycle: sample the request, clock, then drive the memory response for the next cycle
  task automatic tick();
    logic acc;
    #1;
    reqObs  = mem.IReq;
    addrObs = mem.IAddr;
    acc     = mem.IReq & mem.IGnt;
    @(posedge CLK);
    @(negedge CLK);
    mem.IValid = 1'b0;
    if (acc) begin
      pend     = 1'b1;
      pendAddr = addrObs;
      cnt      = lat;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mem.IValid = 1'b1;
        mem.IRdata = pendAddr | 32'hA000_0000;
        pend       = 1'b0;
      end
    end
  endtask

  initial begin
    CLR = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; PCBranchE = 32'h0;
    mem.IGnt = 1'b1; mem.IValid = 1'b0; mem.IRdata = 32'h0;
    lat = 1; cnt = 0; pend = 1'b0; pendAddr = 32'h0;
    @(negedge CLK);

    // Reset
    tick();
    checkVal("rst_ireq", {31'd0, reqObs}, 32'd0);
    tick();
    chkD("rst", 32'h0, 32'h0, 1'b0);
    checkVal("rst_pc4", PCPlus4D, 32'h0);
    checkVal("rst_busy", {31'd0, IMemBusy}, 32'd0);
    checkVal("rst_iaddr", mem.IAddr, 32'h0);
    CLR = 1'b1;

    // Straight-line fetch, 1-cycle memory
    tick();
    checkVal("s1_req0", {31'd0, reqObs}, 32'd1);
    checkVal("s1_addr0", addrObs, 32'h0);
    checkVal("s1_busy", {31'd0, IMemBusy}, 32'd1);
    tick();
    checkVal("s1_gap", {31'd0, reqObs}, 32'd0);
    chkD("s1_bub0", 32'h0, 32'h0, 1'b0);
    tick();
    checkVal("s1_addr4", addrObs, 32'h4);
    chkD("s1_i0", 32'hA000_0000, 32'h4, 1'b1);
    tick();
    chkD("s1_bub1", 32'h0, 32'h0, 1'b0);
    tick();
    checkVal("s1_addr8", addrObs, 32'h8);
    chkD("s1_i1", 32'hA000_0004, 32'h8, 1'b1);

    // Stall F and D for three cycles
    StallD = 1'b1; StallF = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("s2_noreq", {31'd0, reqObs}, 32'd0);
      chkD("s2_hold", 32'hA000_0004, 32'h8, 1'b1);
    end
`ifdef FETCH_PERF_CNT_EN
    checkVal("s2_stallcnt", StallCnt, 32'd3);
`endif
    StallD = 1'b0; StallF = 1'b0;
    tick();
    checkVal("s2_addr12", addrObs, 32'hC);
    chkD("s2_i2", 32'hA000_0008, 32'hC, 1'b1);
    tick();
    lat = 3;
    tick();
    checkVal("s2_addr16", addrObs, 32'h10);
    chkD("s2_i3", 32'hA000_000C, 32'h10, 1'b1);

    // Redirect while waiting; response lands two cycles later in DRAIN
    PCSrcE = 1'b1; PCBranchE = 32'h0000_0100;
    tick();
    checkVal("s3_noreq", {31'd0, reqObs}, 32'd0);
    chkD("s3_flush", 32'h0, 32'h0, 1'b0);
    checkVal("s3_busy0", {31'd0, IMemBusy}, 32'd1);
    PCSrcE = 1'b0;
    tick();
    checkVal("s3_busy1", {31'd0, IMemBusy}, 32'd1);
    lat = 1;
    tick();
    checkVal("s3_busy2", {31'd0, IMemBusy}, 32'd0);
    chkD("s3_drop", 32'h0, 32'h0, 1'b0);
    tick();
    checkVal("s3_req", {31'd0, reqObs}, 32'd1);
    checkVal("s3_addr", addrObs, 32'h100);
    tick();
    tick();
    checkVal("s3_addr104", addrObs, 32'h104);
    chkD("s3_i", 32'hA000_0100, 32'h104, 1'b1);

    // Redirect and response in the same WAIT cycle, with StallD high
    PCSrcE = 1'b1; PCBranchE = 32'h0000_0200; StallD = 1'b1;
    tick();
    chkD("s4_flush", 32'h0, 32'h0, 1'b0);
    checkVal("s4_busy", {31'd0, IMemBusy}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkVal("s4_squashcnt", SquashCnt, 32'd2);
`endif
    PCSrcE = 1'b0; StallD = 1'b0;
    tick();
    checkVal("s4_addr", addrObs, 32'h200);
    tick();

    // Grant withheld for four cycles, then 3-cycle latency
    mem.IGnt = 1'b0;
    tick();
    checkVal("s5_addr_a", addrObs, 32'h204);
    chkD("s5_i", 32'hA000_0200, 32'h204, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("s5_req_held", {31'd0, reqObs}, 32'd1);
      checkVal("s5_addr_held", addrObs, 32'h204);
      chkD("s5_bub", 32'h0, 32'h0, 1'b0);
    end
    mem.IGnt = 1'b1; lat = 3;
    tick();
    checkVal("s5_req_acc", {31'd0, reqObs}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("s5_noreq", {31'd0, reqObs}, 32'd0);
      chkD("s5_wait", 32'h0, 32'h0, 1'b0);
    end
    tick();
    checkVal("s5_addr_n", addrObs, 32'h208);
    chkD("s5_data", 32'hA000_0204, 32'h208, 1'b1);

    // Reset while waiting; stale response arrives afterwards
    CLR = 1'b0; mem.IGnt = 1'b0;
    tick();
    checkVal("s6_rst_req", {31'd0, reqObs}, 32'd0);
    chkD("s6_rst", 32'h0, 32'h0, 1'b0);
    checkVal("s6_rst_pc4", PCPlus4D, 32'h0);
    CLR = 1'b1;
    tick();
    checkVal("s6_addr", addrObs, 32'h0);
    tick();
    chkD("s6_stale", 32'h0, 32'h0, 1'b0);
    checkVal("s6_busy", {31'd0, IMemBusy}, 32'd0);
    tick();
    chkD("s6_after", 32'h0, 32'h0, 1'b0);
    checkVal("s6_iaddr", mem.IAddr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkVal("s6_stallcnt", StallCnt, 32'd0);
    checkVal("s6_squashcnt", SquashCnt, 32'd0);
`endif

    // Redirect in FETCH to the top word, then PC wrap
    mem.IGnt = 1'b1; lat = 1; PCSrcE = 1'b1; PCBranchE = 32'hFFFF_FFFC;
    tick();
    checkVal("s7_noreq", {31'd0, reqObs}, 32'd0);
    PCSrcE = 1'b0;
    tick();
    checkVal("s7_addr_top", addrObs, 32'hFFFF_FFFC);
    tick();
    tick();
    checkVal("s7_addr_wrap", addrObs, 32'h0);
    chkD("s7_i", 32'hFFFF_FFFC, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
